// File: rtl/mc10_tape_pkg.sv
// rtl/mc10_tape_pkg.sv - shared types and 50 MHz default constants for the MC-10 tape decoder
package mc10_tape_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } tape_state_t;

  // Defaults for a 50 MHz clk: 1200 Hz full cycle ~41667, 2400 Hz ~20833.
  localparam int unsigned FILTER_LEN_DEF = 64;
  localparam int unsigned PERIOD_W_DEF   = 17;
  localparam int unsigned MIN_P_DEF      = 15000;
  localparam int unsigned THRESH_DEF     = 31250;
  localparam int unsigned MAX_P_DEF      = 50000;

endpackage

// File: rtl/mc10_tape_decoder_if.sv
// rtl/mc10_tape_decoder_if.sv - decoded tape outputs bundle (level, period, bit, carrier, errors)
//
// master : driven by mc10_tape_decoder
// slave  : consumed by CPU port B / debug display
//   tape_level   filtered tape level
//   period       last accepted full-cycle period
//   period_valid one-cycle pulse, period updated
//   bit_valid    one-cycle pulse, coincident with period_valid
//   bit_value    decoded bit, held until next bit_valid
//   carrier      high while locked
//   err_count    saturating count of short-period glitches
interface mc10_tape_decoder_if
  import mc10_tape_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
);
  logic                tape_level;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                bit_valid;
  logic                bit_value;
  logic                carrier;
  logic [7:0]          err_count;

  modport master (
    output tape_level, period, period_valid, bit_valid, bit_value, carrier, err_count
  );

  modport slave (
    input tape_level, period, period_valid, bit_valid, bit_value, carrier, err_count
  );
endinterface

// File: rtl/tape_glitch_filter.sv
// rtl/tape_glitch_filter.sv - run-length glitch filter for the synchronized tape comparator
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high
//   tape_i  synchronized raw tape input
//   level_o filtered level; flips after FILTER_LEN consecutive differing samples
module tape_glitch_filter
  import mc10_tape_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tape_i,
  output logic level_o
);
  localparam int unsigned FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);

  logic [FC_W-1:0] fc_q;
  logic            level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q    <= '0;
      level_q <= 1'b0;
    end else if (tape_i == level_q) begin
      fc_q <= '0;
    end else if (fc_q == FC_LAST) begin
      // This is the FILTER_LEN-th consecutive differing sample.
      level_q <= ~level_q;
      fc_q    <= '0;
    end else begin
      fc_q <= fc_q + FC_W'(1);
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/mc10_tape_decoder.sv
// rtl/mc10_tape_decoder.sv - MC-10 cassette front end: glitch filter, FSK period measure, carrier lock
//
// Ports:
//   clk     system clock (clk_50)
//   reset   synchronous, active-high
//   tape_in tape input, already synchronized to clk
//   dec     mc10_tape_decoder_if master: tape_level, period, period_valid,
//           bit_valid, bit_value, carrier, err_count (all registered)
module mc10_tape_decoder
  import mc10_tape_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
  parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
  parameter int unsigned MIN_P      = MIN_P_DEF,
  parameter int unsigned THRESH     = THRESH_DEF,
  parameter int unsigned MAX_P      = MAX_P_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tape_in,
  mc10_tape_decoder_if.master dec
);
  localparam int unsigned MW = PERIOD_W + 1;
  localparam logic [MW-1:0] MIN_M = MW'(MIN_P);
  localparam logic [MW-1:0] THR_M = MW'(THRESH);
  localparam logic [MW-1:0] MAX_M = MW'(MAX_P);

  logic                level;
  logic                level_prev_q;
  logic                rise;
  logic [PERIOD_W-1:0] pc_q;
  logic [MW-1:0]       m;
  tape_state_t         state_q;
  logic [PERIOD_W-1:0] period_q;
  logic                period_valid_q;
  logic                bit_valid_q;
  logic                bit_value_q;
  logic [7:0]          err_count_q;

  tape_glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .tape_i  (tape_in),
    .level_o (level)
  );

  assign rise = level & ~level_prev_q;

  // One bit wider than pc so a saturated counter still reads as "too long".
  assign m = {1'b0, pc_q} + MW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      level_prev_q   <= 1'b0;
      pc_q           <= '0;
      state_q        <= IDLE;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      bit_valid_q    <= 1'b0;
      bit_value_q    <= 1'b0;
      err_count_q    <= '0;
    end else begin
      level_prev_q   <= level;
      period_valid_q <= 1'b0;
      bit_valid_q    <= 1'b0;

      if (rise) begin
        pc_q <= '0;
      end else if (pc_q != '1) begin
        pc_q <= pc_q + PERIOD_W'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= SYNC;
          end
        end
        SYNC, LOCKED: begin
          // A rise wins over a coincident timeout; it then falls under m > MAX_P.
          if (rise) begin
            if (m < MIN_M) begin
              state_q <= SYNC;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
            end else if (m > MAX_M) begin
              state_q <= SYNC;
            end else begin
              period_q       <= m[PERIOD_W-1:0];
              period_valid_q <= 1'b1;
              bit_valid_q    <= 1'b1;
              bit_value_q    <= (m < THR_M);
              state_q        <= LOCKED;
            end
          end else if (m > MAX_M) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dec.tape_level   = level;
  assign dec.period       = period_q;
  assign dec.period_valid = period_valid_q;
  assign dec.bit_valid    = bit_valid_q;
  assign dec.bit_value    = bit_value_q;
  assign dec.carrier      = (state_q == LOCKED);
  assign dec.err_count    = err_count_q;

endmodule

// File: tb/tb_mc10_tape_decoder.sv
// tb/tb_mc10_tape_decoder.sv - directed self-checking bench for mc10_tape_decoder
module tb_mc10_tape_decoder;

  localparam int FILTER_LEN = 64;
  localparam int PERIOD_W   = 10;
  localparam int MIN_P      = 300;
  localparam int THRESH     = 625;
  localparam int MAX_P      = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tape_in = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int pq[$];
  int bq[$];
  int coinc_err = 0;
  logic lvl_seen = 1'b0;

  mc10_tape_decoder_if #(.PERIOD_W(PERIOD_W)) dif ();

  mc10_tape_decoder #(
    .FILTER_LEN (FILTER_LEN),
    .PERIOD_W   (PERIOD_W),
    .MIN_P      (MIN_P),
    .THRESH     (THRESH),
    .MAX_P      (MAX_P)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tape_in (tape_in),
    .dec     (dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (dif.period_valid) begin
      pq.push_back(int'(dif.period));
      bq.push_back(int'(dif.bit_value));
    end
    if (dif.period_valid != dif.bit_valid) coinc_err++;
    if (dif.tape_level) lvl_seen = 1'b1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic play(input int p);
    tape_in = 1'b1;
    repeat (p / 2) tick();
    tape_in = 1'b0;
    repeat (p - p / 2) tick();
  endtask

  task automatic play_seq(input int ps[]);
    foreach (ps[i]) play(ps[i]);
  endtask

  task automatic final_rise();
    tape_in = 1'b1;
    repeat (150) tick();
    tape_in = 1'b0;
  endtask

  task automatic idle_out();
    repeat (1200) tick();
  endtask

  task automatic check_seq(input string tag, input int ep[]);
    check({tag, "_count"}, pq.size(), ep.size());
    for (int i = 0; i < ep.size() && i < pq.size(); i++) begin
      check($sformatf("%s_period%0d", tag, i), pq[i], ep[i]);
      check($sformatf("%s_bit%0d", tag, i), bq[i], (ep[i] < THRESH) ? 1 : 0);
    end
    pq.delete();
    bq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, int'(dif.tape_level), 0);
    check({tag, "_period"}, int'(dif.period), 0);
    check({tag, "_bit"}, int'(dif.bit_value), 0);
    check({tag, "_carrier"}, int'(dif.carrier), 0);
    check({tag, "_err"}, int'(dif.err_count), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int seq_a[] = '{417, 417, 417, 833, 833, 417, 833, 417};
    int seq_c[] = '{417, 1000, 300, 624, 625};
    int seq_d[] = '{417, 299, 417};
    int exp_d[] = '{417, 417};
    int seq_e[] = '{417, 1001, 417};
    int exp_e[] = '{417, 417};
    int exp_b[] = '{417, 417, 417};

    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    repeat (2000) tick();
    check_all_zero("idle");
    check("idle_pulses", pq.size(), 0);

    lvl_seen = 1'b0;
    tape_in = 1'b1; repeat (10) tick(); tape_in = 1'b0; repeat (100) tick();
    tape_in = 1'b1; repeat (63) tick(); tape_in = 1'b0; repeat (100) tick();
    check("short_pulses", int'(lvl_seen), 0);

    tape_in = 1'b1;
    cnt = 0;
    while (!dif.tape_level && cnt < 200) begin
      tick();
      cnt++;
    end
    check("filter_latency", cnt, FILTER_LEN);
    tape_in = 1'b0;
    idle_out();
    check("single_rise_carrier", int'(dif.carrier), 0);
    check("single_rise_pulses", pq.size(), 0);

    play_seq(seq_a);
    final_rise();
    check("seqa_carrier", int'(dif.carrier), 1);
    check("seqa_period_hold", int'(dif.period), 417);
    check("seqa_bit_hold", int'(dif.bit_value), 1);
    check_seq("seqa", seq_a);

    cnt = 150;
    while (dif.carrier && cnt < 3000) begin
      tick();
      cnt++;
    end
    check("timeout_cycle", cnt, 1066);
    idle_out();

    play(417);
    play(417);
    play(200);
    tape_in = 1'b1;
    repeat (80) tick();
    check("glitch_carrier", int'(dif.carrier), 0);
    check("glitch_err", int'(dif.err_count), 1);
    repeat (208 - 80) tick();
    tape_in = 1'b0;
    repeat (209) tick();
    final_rise();
    check("relock_carrier", int'(dif.carrier), 1);
    check_seq("seqb", exp_b);
    idle_out();

    play_seq(seq_c);
    final_rise();
    check_seq("seqc", seq_c);
    check("seqc_err", int'(dif.err_count), 1);
    idle_out();

    play_seq(seq_d);
    final_rise();
    check_seq("seqd", exp_d);
    check("seqd_err", int'(dif.err_count), 2);
    idle_out();

    play_seq(seq_e);
    final_rise();
    check_seq("seqe", exp_e);
    check("seqe_err", int'(dif.err_count), 2);
    check("seqe_carrier", int'(dif.carrier), 1);

    play(417);
    tape_in = 1'b1;
    repeat (100) tick();
    check("prereset_err", int'(dif.err_count), 2);
    check("prereset_carrier", int'(dif.carrier), 1);
    reset = 1'b1;
    tape_in = 1'b0;
    tick();
    reset = 1'b0;
    check_all_zero("midreset");

    check("pv_bv_coincident", coinc_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
